sha256_block_sequencer: RTL and testbench

- Control FSM that sequences one SHA-256 hash over NUM_BLOCKS 512-bit message blocks.
- Requests each message block and loads the working variables from the H accumulators.
- Steps the round index through all compression rounds, then commits the result.
- Commits by driving the 2-bit Block code consumed by the eight H-word accumulators (0 = reload IV, k = add working vars after block k).
- Signals done when the digest in the accumulators is final.

---
 rtl/sha_pkg.sv | 62 ++++++
 rtl/sha_round_counter.sv | 48 ++++
 rtl/sha256_block_sequencer.sv | 154 +++++++++++++++
 tb/tb_sha256_block_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sha_pkg
//  Description : Shared SHA-256 types and constants (FSM states, block codes,
//                IV and round constants).
//  Revision    : 1.0 - initial release
// ============================================================================
package sha_pkg;

    localparam int SHA256_ROUNDS = 64;

    localparam logic [1:0] BLK_IV = 2'd0;
    localparam logic [1:0] BLK_1  = 2'd1;
    localparam logic [1:0] BLK_2  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MSG = 3'd1,
        ST_LOAD     = 3'd2,
        ST_ROUND    = 3'd3,
        ST_ACCUM    = 3'd4,
        ST_DONE     = 3'd5
    } sha_state_e;

    localparam logic [31:0] H0 = 32'h6a09e667;
    localparam logic [31:0] H1 = 32'hbb67ae85;
    localparam logic [31:0] H2 = 32'h3c6ef372;
    localparam logic [31:0] H3 = 32'ha54ff53a;
    localparam logic [31:0] H4 = 32'h510e527f;
    localparam logic [31:0] H5 = 32'h9b05688c;
    localparam logic [31:0] H6 = 32'h1f83d9ab;
    localparam logic [31:0] H7 = 32'h5be0cd19;

    // H0 occupies the most significant word, matching digest byte order.
    localparam logic [255:0] SHA256_IV = {H0, H1, H2, H3, H4, H5, H6, H7};

    localparam logic [31:0] K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sha_k(input logic [5:0] idx);
        return K_TABLE[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha_round_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sha_round_counter
//  Description : Round index counter with clear, enable and terminal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha_round_counter
    import sha_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [5:0] o_count,
    output logic       o_tc
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    logic [5:0] count_q;
    logic [5:0] count_d;

    // Wraps to zero on the terminal round so no extra round index is produced.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = (count_q == LAST_IDX) ? 6'd0 : count_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = (count_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/sha256_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sha256_block_sequencer
//  Description : Control FSM sequencing one SHA-256 hash over NUM_BLOCKS
//                message blocks; all outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_block_sequencer
    import sha_pkg::*;
#(
    parameter int ROUNDS     = SHA256_ROUNDS,
    parameter int NUM_BLOCKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       msg_valid,
    output logic       msg_req,
    output logic       msg_ack,
    output logic       init_wv,
    output logic       round_en,
    output logic [5:0] round_idx,
    output logic [1:0] block,
    output logic       acc_en,
    output logic       busy,
    output logic       done
);

    sha_state_e state_q, state_d;
    logic [1:0] blk_cnt_q, blk_cnt_d;
    logic [1:0] block_q, block_d;
    logic       msg_req_q, msg_req_d;
    logic       msg_ack_q, msg_ack_d;
    logic       init_wv_q, init_wv_d;
    logic       round_en_q, round_en_d;
    logic       acc_en_q, acc_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic       w_round_tc;
    logic [1:0] w_blk_next;
    logic       w_last_blk;

    assign w_blk_next = blk_cnt_q + 2'd1;
    assign w_last_blk = (w_blk_next == 2'(NUM_BLOCKS));

    // The counter only runs in ROUND; anything else (or abort) parks it at 0.
    assign w_cnt_clr = abort || (state_q != ST_ROUND);
    assign w_cnt_en  = (state_q == ST_ROUND);

    sha_round_counter #(
        .ROUNDS (ROUNDS)
    ) u_round_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (round_idx),
        .o_tc    (w_round_tc)
    );

    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        block_d   = block_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_WAIT_MSG;
                    blk_cnt_d = 2'd0;
                    block_d   = BLK_IV;
                end
            end
            ST_WAIT_MSG: begin
                if (msg_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (w_round_tc) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                block_d   = w_blk_next;
                blk_cnt_d = w_blk_next;
                state_d   = w_last_blk ? ST_DONE : ST_WAIT_MSG;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d   = ST_IDLE;
            blk_cnt_d = 2'd0;
            block_d   = BLK_IV;
        end

        msg_req_d  = (state_d == ST_WAIT_MSG);
        msg_ack_d  = (state_q == ST_WAIT_MSG) && (state_d == ST_LOAD);
        init_wv_d  = (state_d == ST_LOAD);
        round_en_d = (state_d == ST_ROUND);
        acc_en_d   = (state_q == ST_ACCUM) && !abort;
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d     = (state_q == ST_ACCUM) && (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            blk_cnt_q  <= 2'd0;
            block_q    <= BLK_IV;
            msg_req_q  <= 1'b0;
            msg_ack_q  <= 1'b0;
            init_wv_q  <= 1'b0;
            round_en_q <= 1'b0;
            acc_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_cnt_q  <= blk_cnt_d;
            block_q    <= block_d;
            msg_req_q  <= msg_req_d;
            msg_ack_q  <= msg_ack_d;
            init_wv_q  <= init_wv_d;
            round_en_q <= round_en_d;
            acc_en_q   <= acc_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign msg_req  = msg_req_q;
    assign msg_ack  = msg_ack_q;
    assign init_wv  = init_wv_q;
    assign round_en = round_en_q;
    assign block    = block_q;
    assign acc_en   = acc_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_block_sequencer
//  Description : Scoreboard bench; a reference SHA-256 datapath is driven by
//                the sequencer outputs and final digests are compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_block_sequencer;
    import sha_pkg::*;

    localparam int ROUNDS = 64;
    localparam int LAT2   = 2 * (ROUNDS + 3);
    localparam int LAT1   = ROUNDS + 3;
    localparam logic [255:0] DIG_2BLK =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    typedef struct {
        int           t0;
        int           lat;
        logic [1:0]   blk;
        logic [255:0] dig;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start1 = 1'b0;
    logic abort = 1'b0;
    logic msg_valid = 1'b0;

    logic       msg_req0, msg_ack0, init_wv0, round_en0, acc_en0, busy0, done0;
    logic [5:0] round_idx0;
    logic [1:0] block0;
    logic       msg_req1, msg_ack1, init_wv1, round_en1, acc_en1, busy1, done1;
    logic [5:0] round_idx1;
    logic [1:0] block1;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_block_sequencer #(.ROUNDS(ROUNDS), .NUM_BLOCKS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .msg_valid(msg_valid), .msg_req(msg_req0), .msg_ack(msg_ack0),
        .init_wv(init_wv0), .round_en(round_en0), .round_idx(round_idx0),
        .block(block0), .acc_en(acc_en0), .busy(busy0), .done(done0)
    );

    sha256_block_sequencer #(.ROUNDS(ROUNDS), .NUM_BLOCKS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .msg_valid(1'b1), .msg_req(msg_req1), .msg_ack(msg_ack1),
        .init_wv(init_wv1), .round_en(round_en1), .round_idx(round_idx1),
        .block(block1), .acc_en(acc_en1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference SHA-256 math ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [2047:0] sched(input logic [511:0] m);
        logic [31:0]   w [64];
        logic [31:0]   s0, s1;
        logic [2047:0] r;
        for (int i = 0; i < 16; i++) w[i] = m[i*32 +: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 64; i++) r[i*32 +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s,
                                               input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        return r;
    endfunction

    // Padded blocks for "abc" and for the 56-byte two-block test vector.
    function automatic logic [511:0] msg_blk(input bit abc, input logic [1:0] idx);
        logic [511:0] m;
        m = '0;
        if (abc) begin
            m[31:0]      = 32'h61626380;
            m[15*32 +: 32] = 32'h00000018;
        end else if (idx == BLK_IV) begin
            for (int i = 0; i < 14; i++)
                for (int j = 0; j < 4; j++)
                    m[i*32 + (3-j)*8 +: 8] = 8'(8'h61 + i + j);
            m[14*32 +: 32] = 32'h80000000;
        end else begin
            m[15*32 +: 32] = 32'h000001c0;
        end
        return m;
    endfunction

    // ---------------- datapath models driven by the sequencers ----------------
    logic [2047:0] w0, w1;
    logic [255:0]  wv0, wv1, hm0, hm1;

    always @(posedge clk) begin
        if (msg_ack0) w0 <= sched(msg_blk(1'b0, block0));
        if (init_wv0) wv0 <= hm0;
        else if (round_en0) wv0 <= sha_round(wv0, sha_k(round_idx0), w0[int'(round_idx0)*32 +: 32]);
        if (block0 == BLK_IV) hm0 <= SHA256_IV;
        else if (acc_en0) hm0 <= add8(hm0, wv0);
    end

    always @(posedge clk) begin
        if (msg_ack1) w1 <= sched(msg_blk(1'b1, block1));
        if (init_wv1) wv1 <= hm1;
        else if (round_en1) wv1 <= sha_round(wv1, sha_k(round_idx1), w1[int'(round_idx1)*32 +: 32]);
        if (block1 == BLK_IV) hm1 <= SHA256_IV;
        else if (acc_en1) hm1 <= add8(hm1, wv1);
    end

    // ---------------- scoreboard monitors ----------------
    logic         pend0 = 1'b0, pend1 = 1'b0;
    logic [255:0] pdig0, pdig1;
    int           exp_idx = 0;

    always @(negedge clk) begin : mon0
        exp_t e;
        if (pend0) begin
            chk("digest0", hm0, pdig0);
            pend0 <= 1'b0;
        end
        if (rst_n) begin
            if (done0) begin
                if (sb0.size() == 0) begin
                    chk("unexpected_done0", 256'd1, 256'd0);
                end else begin
                    e = sb0.pop_front();
                    chk("latency0", 256'(cyc - e.t0), 256'(e.lat));
                    chk("block_at_done0", 256'(block0), 256'(e.blk));
                    pdig0 <= e.dig;
                    pend0 <= 1'b1;
                end
            end
            if (init_wv0) exp_idx <= 0;
            if (round_en0) begin
                chk("round_idx0", 256'(round_idx0), 256'(exp_idx));
                exp_idx <= exp_idx + 1;
            end
            if (acc_en0) chk("rounds_per_block0", 256'(exp_idx), 256'(ROUNDS));
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (pend1) begin
            chk("digest_abc", hm1, pdig1);
            pend1 <= 1'b0;
        end
        if (rst_n && done1) begin
            if (sb1.size() == 0) begin
                chk("unexpected_done1", 256'd1, 256'd0);
            end else begin
                e = sb1.pop_front();
                chk("latency1", 256'(cyc - e.t0), 256'(e.lat));
                chk("block_at_done1", 256'(block1), 256'(e.blk));
                pdig1 <= e.dig;
                pend1 <= 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input bit expect_done, input int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        if (expect_done) begin
            e.t0 = cyc + 1; e.lat = lat; e.blk = BLK_2; e.dig = DIG_2BLK;
            sb0.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb0.size() != 0 || pend0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk({"timeout_", tag}, 256'd1, 256'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 256'(busy0), 256'd0);
        chk({tag, "_block"}, 256'(block0), 256'(BLK_IV));
        chk({tag, "_round_idx"}, 256'(round_idx0), 256'd0);
        chk({tag, "_round_en"}, 256'(round_en0), 256'd0);
        chk({tag, "_msg_req"}, 256'(msg_req0), 256'd0);
        chk({tag, "_done"}, 256'(done0), 256'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        exp_t e1;
        bit   found;
        int   t0;

        msg_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_idle("idle");

        // Single-block "abc" instance runs alongside the first nominal hash.
        start1 = 1'b1;
        e1.t0 = cyc + 1; e1.lat = LAT1; e1.blk = BLK_1; e1.dig = DIG_ABC;
        sb1.push_back(e1);
        pulse_start(1'b1, LAT2);
        start1 = 1'b0;
        drain("nominal", 400);
        chk("done_hold_block", 256'(block0), 256'(BLK_2));
        chk("done_hold_pulse", 256'(done0), 256'd0);
        chk("done_hold_busy", 256'(busy0), 256'd0);

        // Message stall after block 1 commits.
        pulse_start(1'b1, LAT2 + 20);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (acc_en0 && block0 == BLK_1) found = 1'b1;
        end
        if (!found) chk("stall_find_accum", 256'd0, 256'd1);
        msg_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_msg_req", 256'(msg_req0), 256'd1);
            chk("stall_block", 256'(block0), 256'(BLK_1));
        end
        msg_valid = 1'b1;
        drain("stall", 400);

        // Abort at round 30 of block 2.
        pulse_start(1'b0, 0);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (round_en0 && block0 == BLK_1 && round_idx0 == 6'd30) found = 1'b1;
        end
        if (!found) chk("abort_find_round", 256'd0, 256'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort");
        repeat (150) @(negedge clk);
        chk("abort_still_idle", 256'(busy0), 256'd0);
        pulse_start(1'b1, LAT2);
        drain("after_abort", 400);

        // Restart from DONE, with an ignored start while busy at cycle 40.
        chk("pre_restart_block", 256'(block0), 256'(BLK_2));
        pulse_start(1'b1, LAT2);
        chk("restart_block", 256'(block0), 256'(BLK_IV));
        chk("restart_busy", 256'(busy0), 256'd1);
        chk("restart_msg_req", 256'(msg_req0), 256'd1);
        repeat (39) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("busy_start", 400);

        // start and abort together: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort");
        repeat (10) @(negedge clk);

        // Reset mid-operation behaves like abort.
        pulse_start(1'b0, 0);
        repeat (50) @(negedge clk);
        t0 = cyc;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("mid_reset");
        repeat (150) @(negedge clk);
        chk("mid_reset_no_restart", 256'(busy0), 256'd0);
        chk("mid_reset_elapsed", 256'(cyc - t0 > 150), 256'd1);

        chk("sb0_empty", 256'(sb0.size()), 256'd0);
        chk("sb1_empty", 256'(sb1.size()), 256'd0);
        chk("inst1_busy", 256'(busy1), 256'd0);
        chk("inst1_msg_req", 256'(msg_req1), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
